// File: rtl/comparador_sequencial.sv
// rtl/comparador_sequencial.sv - bit-serial MSB-first unsigned magnitude comparator
module comparador_sequencial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;

    // Control FSM: capture operands, walk bit pairs from the MSB, stop at the first difference or bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= IW'(WIDTH - 1);
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        eq    <= 1'b0;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_q[idx] && !b_q[idx]) begin
                        gt    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!a_q[idx] && b_q[idx]) begin
                        lt    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (idx == '0) begin
                        // Every bit pair matched: operands are equal
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    // Result flags stay put until the next accepted start
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_sequencial.sv
// tb/tb_comparador_sequencial.sv - self-checking bench for comparador_sequencial
module tb_comparador_sequencial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;

    int errors = 0;
    int checks = 0;

    comparador_sequencial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: latency is W minus the highest differing bit index, W when equal
    function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int k;
        d = x ^ y;
        k = W;
        for (int j = 0; j < W; j++)
            if (d[j]) k = W - j;
        return k;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
        int ix;
        int iy;
        ix = int'(x);
        iy = int'(y);
        if (ix > iy) return 3'b100;
        if (ix < iy) return 3'b010;
        return 3'b001;
    endfunction

    // One full operation; operands wiggle during COMPARE, optionally with start re-asserted
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit repulse, input string tag);
        int         k;
        int         cyc;
        logic [2:0] ef;
        k  = ref_k(ta, tb_v);
        ef = ref_flags(ta, tb_v);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = repulse;
        if (repulse) begin
            a = '0;
            b = '1;
        end
        chk({tag, "_busy_start"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc <= 4 * W) begin
            chk({tag, "_flags_compare"}, {gt, lt, eq}, 3'b000);
            @(negedge clk);
            cyc++;
            if (!repulse) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_latency"}, cyc, k);
        chk({tag, "_flags"}, {gt, lt, eq}, ef);
        chk({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_idle_after"}, {busy, done, gt, lt, eq}, {2'b00, ef});
    endtask

    int tq[$];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        chk("reset_outputs", {busy, done, gt, lt, eq}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, gt, lt, eq}, 5'b00000);

        run_op(4'b1010, 4'b0110, 1'b0, "r029");
        run_op(4'b0010, 4'b0011, 1'b0, "r030");
        run_op(4'b0101, 4'b0101, 1'b0, "r031");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("r031_hold", {busy, done, gt, lt, eq}, 5'b00001);
        end

        run_op(4'b1100, 4'b0011, 1'b1, "r032");

        // Asynchronous reset in the middle of a comparison
        @(negedge clk);
        a     = 4'b0001;
        b     = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("r033_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("r033_async_clear", {busy, done, gt, lt, eq}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("r033_no_done", {busy, done}, 2'b00);
        end
        run_op(4'b0000, 4'b1111, 1'b0, "r033_after");

        // Random operands against the reference
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");

        // Start held high: done pulses must recur every k+2 cycles
        @(negedge clk);
        a     = 4'b0111;
        b     = 4'b0111;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                tq.push_back(i);
                chk("r034_flags", {gt, lt, eq}, 3'b001);
            end
        end
        start = 1'b0;
        chk("r034_pulse_count", tq.size(), 6);
        if (tq.size() > 0) chk("r034_first", tq[0], 4);
        for (int i = 1; i < tq.size(); i++)
            chk("r034_spacing", tq[i] - tq[i-1], 6);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("final_idle", {busy, done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comparador_sequencial.md
COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to compare a and b.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A (unsigned).
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B (unsigned).
REQ-007 The block SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have ports gt, lt and eq, each an output of 1 bit, meaning A>B, A<B and A==B respectively.

Function
REQ-010 The FSM SHALL have exactly three states, IDLE, COMPARE and DONE, and SHALL reset to IDLE.
REQ-011 IDLE: when start=1 at a rising edge, a and b SHALL be captured into internal registers, the bit index SHALL be set to WIDTH-1, and gt/lt/eq SHALL be cleared to 0.
REQ-012 On an accepted start (REQ-011), the FSM SHALL go to COMPARE.
REQ-013 IDLE: with start=0, the block SHALL hold all outputs and remain in IDLE.
REQ-014 COMPARE, one captured bit pair per cycle, MSB first, at index i: A[i]=1 and B[i]=0 SHALL set gt=1 and move the FSM to DONE.
REQ-015 COMPARE at index i: A[i]=0 and B[i]=1 SHALL set lt=1 and move the FSM to DONE.
REQ-016 COMPARE at index i with equal bits: i=0 SHALL set eq=1 and move the FSM to DONE; otherwise the index SHALL decrement and the FSM SHALL stay in COMPARE.
REQ-017 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-018 busy SHALL be 1 in COMPARE and DONE, and 0 in IDLE.
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E0+k, where k=WIDTH-j, j is the highest differing bit index, and k=WIDTH when a==b.
REQ-020 Exactly one of gt/lt/eq SHALL be 1 from the done cycle until the next accepted start; all three SHALL be 0 during COMPARE.
REQ-021 start SHALL be ignored in COMPARE and DONE.
REQ-022 a and b changing after capture SHALL NOT affect the result in progress.
REQ-023 Back-to-back operation: start=1 in the first IDLE cycle after DONE SHALL be accepted.
REQ-024 The minimum spacing between done pulses SHALL be k+2 cycles.
REQ-025 The index counter SHALL NOT wrap; index 0 always terminates COMPARE.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set busy, done, gt, lt, eq, the index and the captured operands to 0.
REQ-027 rst_n asserted mid-COMPARE SHALL abort the comparison; no done pulse SHALL be produced for the aborted operation.
REQ-028 After rst_n deasserts, the first start SHALL be honoured normally.

Verification (WIDTH=4)
REQ-029 a=1010, b=0110, start pulsed -> k=1; done after 1 COMPARE cycle with gt=1, lt=0, eq=0; busy high 2 cycles.
REQ-030 a=0010, b=0011, start pulsed -> k=4; lt=1 with done in the cycle after E0+4.
REQ-031 a=b=0101 -> k=4; eq=1 only; results held unchanged for 10 idle cycles after done.
REQ-032 a=1100, b=0011 accepted, then start re-pulsed with a=0000, b=1111 during COMPARE -> second start ignored; result gt=1, single done pulse.
REQ-033 a=0001, b=0000 started, rst_n=0 pulsed mid-COMPARE between clock edges -> all outputs 0 immediately, no done; next start with a=0000, b=1111 -> lt=1 at k=1.
REQ-034 start held high continuously with a=0111, b=0111 -> eq=1 pulses every 6 cycles (k=4, +2), no lost or merged done pulses.
